commit_trace_buffer: RTL and testbench

//  Synthesizable retire-trace recorder for the pipelined cpu. Samples WB register writes, MEM loads/stores and halt each cycle.

---
 rtl/commit_trace_buffer.sv | 142 ++++++++++++++
 tb/tb_commit_trace_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: samples retire events (WB reg write, MEM load/store,
// halt) once per cycle, packs them into one record and queues them in a
// first-word-fall-through FIFO drained over a valid/ready port. Also keeps
// saturating cycle / retired-instruction / dropped-record counters.
// Optional feature macro: TRACE_TIMESTAMP_EN -- when defined, each record
// carries the cycle_count stamp and trc_cycle presents it; otherwise the
// stamp is not stored and trc_cycle is 0.
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_regwraddr,
  input  logic [DATA_W-1:0] wb_regwrdata,
  input  logic              mem_memread,
  input  logic              mem_memwrite,
  input  logic [ADDR_W-1:0] mem_dataaddr,
  input  logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              hlt,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [3:0]        trc_flags,
  output logic [REG_AW-1:0] trc_reg,
  output logic [DATA_W-1:0] trc_regdata,
  output logic [ADDR_W-1:0] trc_memaddr,
  output logic [DATA_W-1:0] trc_memdata,
  output logic [CNT_W-1:0]  trc_cycle,
  output logic [LW-1:0]     level,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted
);

  typedef struct packed {
    logic [3:0]        flags;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  rec_t              mem_q [DEPTH];
  rec_t              rec_d, head;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]  cycle_q, inst_q, drop_q;
  logic              ovf_q, halted_q;
  logic              ev, push, pop, full, wr, drop, retire;

  // Event decode and FIFO handshake; a pop frees a slot for a same-edge push.
  always_comb begin
    ev     = wb_regwrite | mem_memread | mem_memwrite | hlt;
    push   = ev & enable & ~halted_q;
    full   = (count_q == LW'(DEPTH));
    pop    = trc_valid & trc_ready;
    wr     = push & (~full | pop);
    drop   = push & full & ~pop;
    retire = (hlt | wb_regwrite | mem_memwrite) & ~halted_q;
    count_d = count_q + LW'(wr) - LW'(pop);
  end

  // Record packing: fields whose flag is clear are zeroed; a store wins memdata.
  always_comb begin
    rec_d       = '0;
    rec_d.flags = {hlt, mem_memwrite, mem_memread, wb_regwrite};
    if (wb_regwrite) begin
      rec_d.rg    = wb_regwraddr;
      rec_d.rdata = wb_regwrdata;
    end
    if (mem_memread | mem_memwrite) rec_d.maddr = mem_dataaddr;
    if (mem_memwrite)     rec_d.mdata = mem_datain;
    else if (mem_memread) rec_d.mdata = mem_dataout;
  end

  // Storage array: no reset needed, outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= rec_d;
  end

  // Pointers, occupancy, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      inst_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (~halted_q && ~&cycle_q) cycle_q <= cycle_q + CNT_W'(1);
      if (retire && ~&inst_q)     inst_q  <= inst_q + CNT_W'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (~&drop_q) drop_q <= drop_q + CNT_W'(1);
      end
      if (hlt) halted_q <= 1'b1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0] stamp_q [DEPTH];

  // Stamp is the cycle count before this edge's increment.
  always_ff @(posedge clk) begin
    if (wr) stamp_q[wr_ptr_q] <= cycle_q;
  end
  assign trc_cycle = trc_valid ? stamp_q[rd_ptr_q] : '0;
`else
  assign trc_cycle = '0;
`endif

  assign head        = mem_q[rd_ptr_q];
  assign trc_valid   = (count_q != '0);
  assign trc_flags   = trc_valid ? head.flags : '0;
  assign trc_reg     = trc_valid ? head.rg    : '0;
  assign trc_regdata = trc_valid ? head.rdata : '0;
  assign trc_memaddr = trc_valid ? head.maddr : '0;
  assign trc_memdata = trc_valid ? head.mdata : '0;
  assign level       = count_q;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model of the trace buffer.
module tb_commit_trace_buffer;
  localparam int DATA_W = 16, ADDR_W = 16, REG_AW = 4, DEPTH = 16, CNT_W = 32;
  localparam int LW = $clog2(DEPTH + 1);

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic              rst_n, enable, wb_regwrite, mem_memread, mem_memwrite, hlt, trc_ready;
  logic [REG_AW-1:0] wb_regwraddr, trc_reg;
  logic [DATA_W-1:0] wb_regwrdata, mem_datain, mem_dataout, trc_regdata, trc_memdata;
  logic [ADDR_W-1:0] mem_dataaddr, trc_memaddr;
  logic              trc_valid, overflow, halted;
  logic [3:0]        trc_flags;
  logic [CNT_W-1:0]  trc_cycle, cycle_count, inst_count, drop_count;
  logic [LW-1:0]     level;

  commit_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
                        .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(gclk), .rst_n(rst_n), .enable(enable),
    .wb_regwrite(wb_regwrite), .wb_regwraddr(wb_regwraddr), .wb_regwrdata(wb_regwrdata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_dataaddr(mem_dataaddr),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout), .hlt(hlt),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_flags(trc_flags),
    .trc_reg(trc_reg), .trc_regdata(trc_regdata), .trc_memaddr(trc_memaddr),
    .trc_memdata(trc_memdata), .trc_cycle(trc_cycle), .level(level),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .overflow(overflow), .halted(halted));

  typedef struct {
    logic [3:0]  f;
    logic [15:0] rg, rd, ma, md;
    longint      st;
  } rec_t;

  rec_t   q[$];
  longint m_cyc, m_inst, m_drop;
  bit     m_ovf, m_hlt;
  int     checks = 0, errors = 0;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_inst = 0; m_drop = 0; m_ovf = 0; m_hlt = 0;
  endtask

  // One clock edge of the trace buffer as described: pop, then push/drop, then counters.
  task automatic model_edge();
    rec_t r;
    bit full, pop, push;
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && trc_ready;
    push = (wb_regwrite || mem_memread || mem_memwrite || hlt) && enable && !m_hlt;
    r.f  = {hlt, mem_memwrite, mem_memread, wb_regwrite};
    r.rg = wb_regwrite ? 16'(wb_regwraddr) : 16'h0;
    r.rd = wb_regwrite ? wb_regwrdata : 16'h0;
    r.ma = (mem_memread || mem_memwrite) ? mem_dataaddr : 16'h0;
    r.md = mem_memwrite ? mem_datain : (mem_memread ? mem_dataout : 16'h0);
    r.st = m_cyc;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drop < CMAX) m_drop++;
      end
    end
    if (!m_hlt) begin
      if (m_cyc < CMAX) m_cyc++;
      if ((hlt || wb_regwrite || mem_memwrite) && m_inst < CMAX) m_inst++;
      if (hlt) m_hlt = 1;
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(q.size()));
    chk("valid", 64'(trc_valid), 64'(q.size() > 0));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("inst_count", 64'(inst_count), 64'(m_inst));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("halted", 64'(halted), 64'(m_hlt));
    if (q.size() > 0) begin
      chk("flags", 64'(trc_flags), 64'(q[0].f));
      chk("reg", 64'(trc_reg), 64'(q[0].rg));
      chk("regdata", 64'(trc_regdata), 64'(q[0].rd));
      chk("memaddr", 64'(trc_memaddr), 64'(q[0].ma));
      chk("memdata", 64'(trc_memdata), 64'(q[0].md));
`ifdef TRACE_TIMESTAMP_EN
      chk("stamp", 64'(trc_cycle), 64'(q[0].st));
`else
      chk("stamp", 64'(trc_cycle), 64'd0);
`endif
    end
  endtask

  task automatic step();
    @(posedge gclk);
    model_edge();
    #1 check_all();
  endtask

  task automatic drive(input bit rw, input int ra, input int rd, input bit mr, input bit mw,
                       input int a, input int di, input int dout, input bit h);
    wb_regwrite = rw; wb_regwraddr = REG_AW'(ra); wb_regwrdata = DATA_W'(rd);
    mem_memread = mr; mem_memwrite = mw; mem_dataaddr = ADDR_W'(a);
    mem_datain = DATA_W'(di); mem_dataout = DATA_W'(dout); hlt = h;
  endtask

  task automatic do_reset();
    @(negedge gclk);
    rst_n = 1'b0;
    model_reset();
    #2 check_all();
    chk("rst_valid", 64'(trc_valid), 64'd0);
    @(negedge gclk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; trc_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12 check_all();
    chk("reset_level", 64'(level), 64'd0);
    @(negedge gclk) rst_n = 1'b1;

    // 1: single regwrite
    drive(1, 3, 'h00AB, 0, 0, 0, 0, 0, 0);
    step();
    chk("t1_flags", 64'(trc_flags), 64'b0001);
    chk("t1_reg", 64'(trc_reg), 64'd3);
    chk("t1_regdata", 64'(trc_regdata), 64'h00AB);
    chk("t1_cycle", 64'(trc_cycle), 64'd0);
    chk("t1_inst", 64'(inst_count), 64'd1);

    // 2: store plus regwrite in one record (readback register deliberately differs)
    drive(1, 1, 'h0005, 0, 1, 'h0040, 'h1234, 'h9999, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_flags", 64'(trc_flags), 64'b0101);
    chk("t2_memdata", 64'(trc_memdata), 64'h1234);
    chk("t2_memaddr", 64'(trc_memaddr), 64'h0040);
    chk("t2_inst", 64'(inst_count), 64'd2);
    repeat (2) step();

    // 3: overflow with ready low, then in-order drain
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, i % 16, i, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_count), 64'd4);
    trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_order", 64'(trc_regdata), 64'(i));
`ifdef TRACE_TIMESTAMP_EN
      chk("t3_stamp", 64'(trc_cycle), 64'(i));
`endif
      step();
    end
    chk("t3_empty", 64'(trc_valid), 64'd0);

    // 4: full FIFO, ready high, push every cycle: level and drops unchanged
    trc_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 2, 'h100 + i, 0, 0, 0, 0, 0, 0);
      step();
    end
    trc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 5, 'h200 + i, 0, 0, 0, 0, 0, 0);
      step();
      chk("t4_level", 64'(level), 64'd16);
      chk("t4_drop", 64'(drop_count), 64'd4);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (18) step();

    // random traffic, occasional halt late in the run
    do_reset();
    for (int i = 0; i < 500; i++) begin
      enable    = ($urandom % 10) != 0;
      trc_ready = (((i / 40) % 2) == 1) ? (($urandom % 8) < 2) : (($urandom % 8) < 7);
      drive($urandom % 2, $urandom, $urandom, $urandom % 3 == 0, $urandom % 3 == 0,
            $urandom, $urandom, $urandom, (i > 420) && ($urandom % 40 == 0));
      if ($urandom % 4 == 0) drive(0, 0, 0, 0, 0, 0, 0, 0, (i > 420) && ($urandom % 40 == 0));
      step();
    end

    // 5: load then halt; later regwrites ignored and cycle_count frozen
    do_reset();
    enable = 1'b1; trc_ready = 1'b1;
    drive(0, 0, 0, 1, 0, 'h0010, 'h7777, 'hBEEF, 0);
    step();
    chk("t5_ld_flags", 64'(trc_flags), 64'b0010);
    chk("t5_ld_data", 64'(trc_memdata), 64'hBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("t5_h_flags", 64'(trc_flags), 64'b1000);
    chk("t5_halted", 64'(halted), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 7, i, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("t5_noval", 64'(trc_valid), 64'd0);
    chk("t5_cyc", 64'(cycle_count), 64'd2);

    // 6: asynchronous reset while holding 5 records and halted
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 'h50 + i, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_level", 64'(level), 64'd5);
    chk("t6_halted", 64'(halted), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("t6_valid", 64'(trc_valid), 64'd0);
    chk("t6_lvl0", 64'(level), 64'd0);
    chk("t6_cyc0", 64'(cycle_count), 64'd0);
    chk("t6_hlt0", 64'(halted), 64'd0);
    @(negedge gclk) rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
